// File: rtl/jbi_min_rq_rhq_ctl.sv
// Pointer and flow controller for the 16-entry request header queue.
// The write side strobes the array directly; the read side prefetches the head into a show-ahead register.
module jbi_min_rq_rhq_ctl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  rhq_enq,
    input  logic                  rhq_deq,
    input  logic [DATA_WIDTH-1:0] rhq_rdata,
    output logic                  rhq_csn_wr,
    output logic [ADDR_WIDTH-1:0] rhq_waddr,
    output logic                  rhq_csn_rd,
    output logic [ADDR_WIDTH-1:0] rhq_raddr,
    output logic                  rhq_head_vld,
    output logic [DATA_WIDTH-1:0] rhq_head_data,
    output logic                  rhq_full,
    output logic                  rhq_empty,
    output logic [ADDR_WIDTH:0]   rhq_count,
    output logic                  rhq_credit,
    output logic                  rhq_ovf_err,
    output logic                  rhq_udf_err
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HEAD  = 2'd2;

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [1:0]            state_r;
    logic                  head_vld_r;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  credit_r;
    logic                  ovf_r;
    logic                  udf_r;

    logic                  accept_enq_s;
    logic                  accept_deq_s;
    logic [ADDR_WIDTH:0]   in_flight_s;
    logic                  has_unread_s;
    logic                  issue_rd_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic [1:0]            state_nxt_s;

    // Handshake qualification and read issue; entries held in the head or in flight are not readable again
    always_comb begin
        accept_enq_s = rst_l & rhq_enq & ~full_r;
        accept_deq_s = rst_l & rhq_deq & head_vld_r;
        in_flight_s  = (ADDR_WIDTH + 1)'(head_vld_r) + (ADDR_WIDTH + 1)'(state_r == ST_FETCH);
        has_unread_s = (count_r > in_flight_s);
        if (state_r == ST_IDLE) begin
            issue_rd_s = rst_l & has_unread_s;
        end else if (state_r == ST_HEAD) begin
            issue_rd_s = rst_l & has_unread_s & rhq_deq;
        end else begin
            issue_rd_s = 1'b0;
        end
        count_nxt_s = count_r + (ADDR_WIDTH + 1)'(accept_enq_s) - (ADDR_WIDTH + 1)'(accept_deq_s);
    end

    // Read FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_rd_s) state_nxt_s = ST_FETCH;
                else            state_nxt_s = ST_IDLE;
            end
            ST_FETCH: state_nxt_s = ST_HEAD;
            ST_HEAD: begin
                if (issue_rd_s)        state_nxt_s = ST_FETCH;
                else if (rhq_deq)      state_nxt_s = ST_IDLE;
                else                   state_nxt_s = ST_HEAD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pointers, occupancy, status flags and one-cycle pulses
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            state_r  <= ST_IDLE;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            credit_r <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            if (accept_enq_s) wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            if (issue_rd_s)   rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            count_r  <= count_nxt_s;
            state_r  <= state_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_CNT);
            empty_r  <= (count_nxt_s == '0);
            credit_r <= accept_deq_s;
            ovf_r    <= rhq_enq & full_r;
            udf_r    <= rhq_deq & ~head_vld_r;
        end
    end

    // Show-ahead head register: loads the array output one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            head_vld_r  <= 1'b0;
            head_data_r <= '0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    head_vld_r  <= 1'b1;
                    head_data_r <= rhq_rdata;
                end
                ST_HEAD: begin
                    if (rhq_deq) head_vld_r <= 1'b0;
                    else         head_vld_r <= head_vld_r;
                end
                default: head_vld_r <= head_vld_r;
            endcase
        end
    end

    assign rhq_csn_wr    = ~accept_enq_s;
    assign rhq_waddr     = wr_ptr_r;
    assign rhq_csn_rd    = ~issue_rd_s;
    assign rhq_raddr     = rd_ptr_r;
    assign rhq_head_vld  = head_vld_r;
    assign rhq_head_data = head_data_r;
    assign rhq_full      = full_r;
    assign rhq_empty     = empty_r;
    assign rhq_count     = count_r;
    assign rhq_credit    = credit_r;
    assign rhq_ovf_err   = ovf_r;
    assign rhq_udf_err   = udf_r;

endmodule

// File: tb/tb_jbi_min_rq_rhq_ctl.sv
// Directed bench for the RHQ controller with a behavioural register-file model attached.
module tb_jbi_min_rq_rhq_ctl;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        enq;
    logic        deq;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        csn_wr;
    logic [3:0]  waddr;
    logic        csn_rd;
    logic [3:0]  raddr;
    logic        head_vld;
    logic [63:0] head_data;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        credit;
    logic        ovf_err;
    logic        udf_err;

    logic [63:0] mem [16];
    logic [63:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          seq   = 0;

    always #5 clk = ~clk;

    jbi_min_rq_rhq_ctl #(.ADDR_WIDTH(4), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst_l(rst_l), .rhq_enq(enq), .rhq_deq(deq), .rhq_rdata(rdata),
        .rhq_csn_wr(csn_wr), .rhq_waddr(waddr), .rhq_csn_rd(csn_rd), .rhq_raddr(raddr),
        .rhq_head_vld(head_vld), .rhq_head_data(head_data), .rhq_full(full),
        .rhq_empty(empty), .rhq_count(count), .rhq_credit(credit),
        .rhq_ovf_err(ovf_err), .rhq_udf_err(udf_err)
    );

    // Register-file model: synchronous write, registered read
    always @(posedge clk) begin
        if (!csn_wr) mem[waddr] <= wdata;
        if (!csn_rd) rdata <= mem[raddr];
    end

    function automatic logic [63:0] dat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i) | (64'(i) << 32);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic d, input logic [63:0] w);
        enq = e; deq = d; wdata = w;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string p);
        check({p, "_csn_wr"},  64'(csn_wr),    64'd1);
        check({p, "_csn_rd"},  64'(csn_rd),    64'd1);
        check({p, "_headvld"}, 64'(head_vld),  64'd0);
        check({p, "_headdat"}, head_data,      64'd0);
        check({p, "_full"},    64'(full),      64'd0);
        check({p, "_empty"},   64'(empty),     64'd1);
        check({p, "_count"},   64'(count),     64'd0);
        check({p, "_credit"},  64'(credit),    64'd0);
        check({p, "_ovf"},     64'(ovf_err),   64'd0);
        check({p, "_udf"},     64'(udf_err),   64'd0);
    endtask

    task automatic do_reset(input string p);
        rst_l = 1'b0;
        drive(1'b0, 1'b0, 64'd0);
        tick();
        rst_l = 1'b1;
        drive(1'b0, 1'b0, 64'd0);
        check_reset(p);
        exp_q.delete();
    endtask

    task automatic wait_head();
        int n = 0;
        while (!head_vld && n < 10) begin
            tick();
            n++;
        end
        check("wait_head", 64'(head_vld), 64'd1);
    endtask

    initial begin
        logic [63:0] w;
        int wp;
        int rp;
        int credits;
        rst_l = 1'b0;
        drive(1'b0, 1'b0, 64'd0);
        tick();
        do_reset("rst0");

        // Single entry: write at cycle 0, read at 1, head visible at 3
        w = dat(seq); seq++;
        drive(1'b1, 1'b0, w);
        check("t1_csn_wr", 64'(csn_wr), 64'd0);
        check("t1_waddr",  64'(waddr),  64'd0);
        exp_q.push_back(w);
        tick();
        drive(1'b0, 1'b0, 64'd0);
        check("t1_csn_rd", 64'(csn_rd), 64'd0);
        check("t1_raddr",  64'(raddr),  64'd0);
        check("t1_count",  64'(count),  64'd1);
        check("t1_empty",  64'(empty),  64'd0);
        tick();
        check("t1_vld_c2", 64'(head_vld), 64'd0);
        check("t1_rd_c2",  64'(csn_rd),   64'd1);
        tick();
        check("t1_vld_c3", 64'(head_vld), 64'd1);
        check("t1_data",   head_data,     exp_q[0]);
        drive(1'b0, 1'b1, 64'd0);
        tick();
        void'(exp_q.pop_front());
        check("t1_credit", 64'(credit),   64'd1);
        check("t1_cnt0",   64'(count),    64'd0);
        check("t1_empty1", 64'(empty),    64'd1);
        check("t1_vld0",   64'(head_vld), 64'd0);

        // Dequeue with no head entry
        drive(1'b0, 1'b1, 64'd0);
        check("t5_csn_rd", 64'(csn_rd), 64'd1);
        tick();
        check("t5_udf",    64'(udf_err), 64'd1);
        check("t5_credit", 64'(credit),  64'd0);
        check("t5_count",  64'(count),   64'd0);
        drive(1'b0, 1'b0, 64'd0);
        tick();
        check("t5_udf0",   64'(udf_err), 64'd0);
        w = dat(seq); seq++;
        drive(1'b1, 1'b0, w);
        check("t5_waddr",  64'(waddr), 64'd1);
        tick();
        drive(1'b0, 1'b0, 64'd0);
        check("t5_raddr",  64'(raddr),  64'd1);
        check("t5_csn_rd0", 64'(csn_rd), 64'd0);
        tick();
        do_reset("rst1");

        // Fill to 16, then one overflow attempt
        for (int i = 0; i < 16; i++) begin
            w = dat(seq); seq++;
            drive(1'b1, 1'b0, w);
            check("t2_csn_wr", 64'(csn_wr), 64'd0);
            check("t2_waddr",  64'(waddr),  64'(i));
            exp_q.push_back(w);
            tick();
            if (i == 14) check("t2_notfull15", 64'(full), 64'd0);
        end
        check("t2_full",  64'(full),  64'd1);
        check("t2_count", 64'(count), 64'd16);
        check("t2_empty", 64'(empty), 64'd0);
        drive(1'b1, 1'b0, dat(99));
        check("t2_ovf_csn", 64'(csn_wr), 64'd1);
        tick();
        check("t2_ovf",     64'(ovf_err), 64'd1);
        check("t2_cnt16",   64'(count),   64'd16);
        drive(1'b0, 1'b0, 64'd0);
        tick();
        check("t2_ovf0",    64'(ovf_err),  64'd0);
        check("t2_headvld", 64'(head_vld), 64'd1);
        check("t2_headdat", head_data,     exp_q[0]);

        // Full queue, enqueue and dequeue together: enqueue is still rejected
        drive(1'b1, 1'b1, dat(98));
        check("t4_csn_wr", 64'(csn_wr), 64'd1);
        check("t4_csn_rd", 64'(csn_rd), 64'd0);
        check("t4_raddr",  64'(raddr),  64'd1);
        tick();
        void'(exp_q.pop_front());
        check("t4_ovf",    64'(ovf_err), 64'd1);
        check("t4_credit", 64'(credit),  64'd1);
        check("t4_count",  64'(count),   64'd15);
        check("t4_full",   64'(full),    64'd0);

        // Steady state: dequeue every other cycle with a refill each time; both pointers wrap
        wp = 0;
        rp = 2;
        credits = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin
                drive(1'b0, 1'b0, 64'd0);
                check("t3_fetch_vld", 64'(head_vld), 64'd0);
            end else begin
                w = dat(seq); seq++;
                drive(1'b1, 1'b1, w);
                check("t3_vld",    64'(head_vld), 64'd1);
                check("t3_data",   head_data,     exp_q[0]);
                check("t3_csn_wr", 64'(csn_wr),   64'd0);
                check("t3_waddr",  64'(waddr),    64'(wp));
                check("t3_csn_rd", 64'(csn_rd),   64'd0);
                check("t3_raddr",  64'(raddr),    64'(rp));
                void'(exp_q.pop_front());
                exp_q.push_back(w);
                wp = (wp + 1) % 16;
                rp = (rp + 1) % 16;
            end
            tick();
            if (credit) credits++;
            check("t3_count", 64'(count), 64'd15);
        end
        check("t3_credits", 64'(credits), 64'd20);

        // Partial fill, two dequeues, then reset mid-operation
        do_reset("rst2");
        for (int i = 0; i < 5; i++) begin
            w = dat(seq); seq++;
            drive(1'b1, 1'b0, w);
            check("t6_waddr", 64'(waddr), 64'(i));
            exp_q.push_back(w);
            tick();
        end
        drive(1'b0, 1'b0, 64'd0);
        for (int j = 0; j < 2; j++) begin
            wait_head();
            check("t6_data", head_data, exp_q[0]);
            drive(1'b0, 1'b1, 64'd0);
            tick();
            void'(exp_q.pop_front());
            check("t6_credit", 64'(credit), 64'd1);
            drive(1'b0, 1'b0, 64'd0);
        end
        check("t6_count3", 64'(count), 64'd3);
        do_reset("rst3");
        tick();
        check("t6_nocredit", 64'(credit), 64'd0);
        check("t6_cnt0",     64'(count),  64'd0);
        w = dat(seq); seq++;
        drive(1'b1, 1'b0, w);
        check("t6_waddr0", 64'(waddr), 64'd0);
        exp_q.push_back(w);
        tick();
        drive(1'b0, 1'b0, 64'd0);
        check("t6_raddr0", 64'(raddr), 64'd0);
        tick();
        tick();
        check("t6_headvld", 64'(head_vld), 64'd1);
        check("t6_headdat", head_data,     exp_q[0]);
        check("t6_count1",  64'(count),    64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
